char_buff: RTL and testbench

- Processing stage directly downstream of the UART command parser. It buffers the character stream of one "process" command in block RAM.
- It slides a STR_LEN-byte window across the buffer and hands each window to the MD5 core. It compares each returned digest against the target hash.
- It reports done/match plus the 0-based byte position of the first match. The matched string is then streamed back one byte per parser request.

---
 rtl/char_buff_pkg.sv | 28 ++
 rtl/char_buff_ram.sv | 30 +++
 rtl/char_buff.sv | 198 +++++++++++++++++++
 tb/tb_char_buff.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/char_buff_pkg.sv
// Shared constants and state encoding for the character buffer / MD5 window search.
// The UART command parser imports the same package.
package char_buff_pkg;

    localparam int STR_LEN_DEF = 19;
    localparam int DEPTH_DEF   = 4096;
    localparam int ADDR_W_DEF  = 12;
    localparam int HASH_W      = 128;
    localparam int CNT_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FILL,
        ST_HASH_START,
        ST_HASH_WAIT,
        ST_ADV_RD,
        ST_ADV_SHIFT,
        ST_FINISH
    } state_e;

    // Usable buffer length for a job: bytes beyond the RAM end are counted but dropped.
    function automatic logic [CNT_W-1:0] clamp_len(input logic [CNT_W-1:0] num_bytes,
                                                   input logic [CNT_W-1:0] depth);
        return (num_bytes > depth) ? depth : num_bytes;
    endfunction

endpackage

// File: rtl/char_buff_ram.sv
// DEPTH x 8 byte buffer: one write port, one registered read port (maps onto iCE40 EBR).
module char_buff_ram
    import char_buff_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_addr_i,
    input  logic [7:0]        wr_data_i,
    input  logic [ADDR_W-1:0] rd_addr_i,
    output logic [7:0]        rd_data_o
);

    logic [7:0] mem [DEPTH];
    logic [7:0] rd_data_q;

    // NOTE: neither the array nor the read register has a reset; a reset would stop
    // block-RAM inference, and every byte is written before the search reads it.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_addr_i] <= wr_data_i;
        end
        rd_data_q <= mem[rd_addr_i];
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/char_buff.sv
// Buffers one job's character stream, slides a STR_LEN-byte window over it through the
// MD5 core, and reports/streams back the first window whose digest matches the target.
module char_buff
    import char_buff_pkg::*;
#(
    parameter int STR_LEN = STR_LEN_DEF,
    parameter int DEPTH   = DEPTH_DEF,
    parameter int ADDR_W  = ADDR_W_DEF
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   proc_start,
    input  logic [CNT_W-1:0]       proc_num_bytes,
    input  logic [7:0]             proc_data,
    input  logic                   proc_data_valid,
    input  logic [HASH_W-1:0]      proc_target_hash,
    input  logic                   proc_match_char_next,
    output logic                   proc_done,
    output logic                   proc_match,
    output logic [CNT_W-1:0]       proc_byte_pos,
    output logic [7:0]             proc_match_char,
    output logic                   md5_start,
    output logic [STR_LEN*8-1:0]   md5_msg,
    input  logic                   md5_done,
    input  logic [HASH_W-1:0]      md5_hash
);

    localparam int FILL_W = $clog2(STR_LEN + 1);
    localparam logic [FILL_W-1:0] FILL_LAST = FILL_W'(STR_LEN);
    localparam logic [FILL_W-1:0] IDX_LAST  = FILL_W'(STR_LEN - 1);

    state_e                    state_q, state_d;
    logic [CNT_W-1:0]          num_q, num_d;
    logic [CNT_W-1:0]          len_q, len_d;
    logic [CNT_W-1:0]          wr_cnt_q, wr_cnt_d;
    logic [CNT_W-1:0]          pos_q, pos_d;
    logic [FILL_W-1:0]         rd_idx_q, rd_idx_d;
    logic [FILL_W-1:0]         fill_cnt_q, fill_cnt_d;
    logic [HASH_W-1:0]         target_q, target_d;
    logic [STR_LEN-1:0][7:0]   window_q, window_d;
    logic                      match_q, match_d;
    logic [CNT_W-1:0]          byte_pos_q, byte_pos_d;

    logic                      ram_we;
    logic [ADDR_W-1:0]         ram_raddr;
    logic [7:0]                ram_rdata;
    state_e                    load_exit;
    logic                      more_windows;
    logic [FILL_W-1:0]         char_sel;

    char_buff_ram #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W)
    ) u_ram (
        .clk       (clk),
        .wr_en_i   (ram_we),
        .wr_addr_i (wr_cnt_q[ADDR_W-1:0]),
        .wr_data_i (proc_data),
        .rd_addr_i (ram_raddr),
        .rd_data_o (ram_rdata)
    );

    // Too short for even one window: report no match without touching the MD5 core.
    assign load_exit    = (len_q < CNT_W'(STR_LEN)) ? ST_FINISH : ST_FILL;
    assign more_windows = ({1'b0, pos_q} + (CNT_W + 1)'(STR_LEN)) < {1'b0, len_q};

    always_comb begin
        // NOTE: every _d takes its _q value first, so no path through the case can infer a latch.
        state_d    = state_q;
        num_d      = num_q;
        len_d      = len_q;
        wr_cnt_d   = wr_cnt_q;
        pos_d      = pos_q;
        rd_idx_d   = rd_idx_q;
        fill_cnt_d = fill_cnt_q;
        target_d   = target_q;
        window_d   = window_q;
        match_d    = match_q;
        byte_pos_d = byte_pos_q;
        ram_we     = 1'b0;
        ram_raddr  = '0;

        unique case (state_q)
            ST_IDLE: begin
                if (proc_match_char_next) begin
                    rd_idx_d = (rd_idx_q == IDX_LAST) ? '0 : rd_idx_q + FILL_W'(1);
                end
            end
            ST_LOAD: begin
                if (wr_cnt_q == num_q) begin
                    state_d = load_exit;
                end else if (proc_data_valid) begin
                    ram_we   = (wr_cnt_q < CNT_W'(DEPTH));
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                    if (wr_cnt_d == num_q) begin
                        state_d = load_exit;
                    end
                end
            end
            ST_FILL: begin
                // Read of address k returns one cycle later, so shifting lags issuing by one.
                ram_raddr = ADDR_W'(fill_cnt_q);
                if (fill_cnt_q != '0) begin
                    window_d = {window_q[STR_LEN-2:0], ram_rdata};
                end
                if (fill_cnt_q == FILL_LAST) begin
                    state_d = ST_HASH_START;
                end else begin
                    fill_cnt_d = fill_cnt_q + FILL_W'(1);
                end
            end
            ST_HASH_START: begin
                state_d = ST_HASH_WAIT;
            end
            ST_HASH_WAIT: begin
                if (md5_done) begin
                    if (md5_hash == target_q) begin
                        state_d    = ST_FINISH;
                        match_d    = 1'b1;
                        byte_pos_d = pos_q;
                    end else if (more_windows) begin
                        state_d = ST_ADV_RD;
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_ADV_RD: begin
                ram_raddr = ADDR_W'(pos_q + CNT_W'(STR_LEN));
                state_d   = ST_ADV_SHIFT;
            end
            ST_ADV_SHIFT: begin
                window_d = {window_q[STR_LEN-2:0], ram_rdata};
                pos_d    = pos_q + CNT_W'(1);
                state_d  = ST_HASH_START;
            end
            ST_FINISH: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // A new job pre-empts whatever is running, including a pending digest.
        if (proc_start) begin
            state_d    = ST_LOAD;
            target_d   = proc_target_hash;
            num_d      = proc_num_bytes;
            len_d      = clamp_len(proc_num_bytes, CNT_W'(DEPTH));
            wr_cnt_d   = '0;
            pos_d      = '0;
            rd_idx_d   = '0;
            fill_cnt_d = '0;
            match_d    = 1'b0;
            byte_pos_d = '0;
            ram_we     = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            num_q      <= '0;
            len_q      <= '0;
            wr_cnt_q   <= '0;
            pos_q      <= '0;
            rd_idx_q   <= '0;
            fill_cnt_q <= '0;
            target_q   <= '0;
            window_q   <= '0;
            match_q    <= 1'b0;
            byte_pos_q <= '0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            len_q      <= len_d;
            wr_cnt_q   <= wr_cnt_d;
            pos_q      <= pos_d;
            rd_idx_q   <= rd_idx_d;
            fill_cnt_q <= fill_cnt_d;
            target_q   <= target_d;
            window_q   <= window_d;
            match_q    <= match_d;
            byte_pos_q <= byte_pos_d;
        end
    end

    // Readback index 0 is the window's first byte, which sits in the MSBs.
    assign char_sel        = IDX_LAST - rd_idx_q;
    assign proc_match_char = window_q[char_sel];
    assign proc_done       = (state_q == ST_FINISH);
    assign md5_start       = (state_q == ST_HASH_START);
    assign md5_msg         = window_q;
    assign proc_match      = match_q;
    assign proc_byte_pos   = byte_pos_q;

endmodule

// File: tb/tb_char_buff.sv
// Directed bench for char_buff: a job table plus hand-written abort, idle and reset
// sequences, with a behavioural MD5 core answering 64 cycles after each md5_start.
module tb_char_buff;
    import char_buff_pkg::*;

    localparam int STR_LEN = STR_LEN_DEF;
    localparam int DEPTH   = DEPTH_DEF;
    localparam int WIN_W   = STR_LEN * 8;
    localparam int NVEC    = 8;
    localparam logic [127:0] UNRELATED = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;

    localparam logic [31:0] MD5_K [64] = '{
        32'hd76aa478, 32'he8c7b756, 32'h242070db, 32'hc1bdceee,
        32'hf57c0faf, 32'h4787c62a, 32'ha8304613, 32'hfd469501,
        32'h698098d8, 32'h8b44f7af, 32'hffff5bb1, 32'h895cd7be,
        32'h6b901122, 32'hfd987193, 32'ha679438e, 32'h49b40821,
        32'hf61e2562, 32'hc040b340, 32'h265e5a51, 32'he9b6c7aa,
        32'hd62f105d, 32'h02441453, 32'hd8a1e681, 32'he7d3fbc8,
        32'h21e1cde6, 32'hc33707d6, 32'hf4d50d87, 32'h455a14ed,
        32'ha9e3e905, 32'hfcefa3f8, 32'h676f02d9, 32'h8d2a4c8a,
        32'hfffa3942, 32'h8771f681, 32'h6d9d6122, 32'hfde5380c,
        32'ha4beea44, 32'h4bdecfa9, 32'hf6bb4b60, 32'hbebfbc70,
        32'h289b7ec6, 32'heaa127fa, 32'hd4ef3085, 32'h04881d05,
        32'hd9d4d039, 32'he6db99e5, 32'h1fa27cf8, 32'hc4ac5665,
        32'hf4292244, 32'h432aff97, 32'hab9423a7, 32'hfc93a039,
        32'h655b59c3, 32'h8f0ccc92, 32'hffeff47d, 32'h85845dd1,
        32'h6fa87e4f, 32'hfe2ce6e0, 32'ha3014314, 32'h4e0811a1,
        32'hf7537e82, 32'hbd3af235, 32'h2ad7d2bb, 32'heb86d391
    };
    localparam int MD5_S [64] = '{
        7, 12, 17, 22, 7, 12, 17, 22, 7, 12, 17, 22, 7, 12, 17, 22,
        5,  9, 14, 20, 5,  9, 14, 20, 5,  9, 14, 20, 5,  9, 14, 20,
        4, 11, 16, 23, 4, 11, 16, 23, 4, 11, 16, 23, 4, 11, 16, 23,
        6, 10, 15, 21, 6, 10, 15, 21, 6, 10, 15, 21, 6, 10, 15, 21
    };

    typedef struct {
        int num_bytes;
        int kind;        // 0: 'a'..'z' repeating, 1: pseudo-random bytes
        int seed;
        int tgt_pos;     // window hashed into the target, -1 for an unrelated target
        int exp_starts;
        bit exp_match;
        int exp_pos;
    } vec_t;

    logic               clk = 1'b0;
    logic               reset;
    logic               proc_start;
    logic [15:0]        proc_num_bytes;
    logic [7:0]         proc_data;
    logic               proc_data_valid;
    logic [127:0]       proc_target_hash;
    logic               proc_match_char_next;
    logic               proc_done;
    logic               proc_match;
    logic [15:0]        proc_byte_pos;
    logic [7:0]         proc_match_char;
    logic               md5_start;
    logic [WIN_W-1:0]   md5_msg;
    logic               md5_done;
    logic [127:0]       md5_hash;

    int                 checks = 0;
    int                 failures = 0;
    int                 cyc = 0;
    logic [7:0]         data_mem [DEPTH];
    int                 start_cyc_q [$];
    int                 done_cyc_q [$];
    int                 done_match_q [$];
    int                 done_pos_q [$];
    int                 pend_at = -1;
    logic [127:0]       pend_hash;
    vec_t               vecs [NVEC];

    char_buff dut (
        .clk                  (clk),
        .reset                (reset),
        .proc_start           (proc_start),
        .proc_num_bytes       (proc_num_bytes),
        .proc_data            (proc_data),
        .proc_data_valid      (proc_data_valid),
        .proc_target_hash     (proc_target_hash),
        .proc_match_char_next (proc_match_char_next),
        .proc_done            (proc_done),
        .proc_match           (proc_match),
        .proc_byte_pos        (proc_byte_pos),
        .proc_match_char      (proc_match_char),
        .md5_start            (md5_start),
        .md5_msg              (md5_msg),
        .md5_done             (md5_done),
        .md5_hash             (md5_hash)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] bswap(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    // Single-block MD5 of a STR_LEN-byte message (byte 0 in the MSBs); digest byte 0 in the MSBs.
    function automatic logic [127:0] md5_win(input logic [WIN_W-1:0] msg);
        logic [7:0]  blk [64];
        logic [31:0] m [16];
        logic [31:0] a, b, c, d, f, tmp;
        int          g;
        for (int i = 0; i < 64; i++) blk[i] = 8'h00;
        for (int i = 0; i < STR_LEN; i++) blk[i] = msg[WIN_W-1-8*i -: 8];
        blk[STR_LEN] = 8'h80;
        blk[56] = 8'(STR_LEN * 8);
        for (int i = 0; i < 16; i++) m[i] = {blk[4*i+3], blk[4*i+2], blk[4*i+1], blk[4*i]};
        a = 32'h67452301; b = 32'hefcdab89; c = 32'h98badcfe; d = 32'h10325476;
        for (int i = 0; i < 64; i++) begin
            if (i < 16)      begin f = (b & c) | (~b & d); g = i; end
            else if (i < 32) begin f = (d & b) | (~d & c); g = (5 * i + 1) % 16; end
            else if (i < 48) begin f = b ^ c ^ d;          g = (3 * i + 5) % 16; end
            else             begin f = c ^ (b | ~d);       g = (7 * i) % 16; end
            f   = f + a + MD5_K[i] + m[g];
            a   = d;
            d   = c;
            c   = b;
            tmp = (f << MD5_S[i]) | (f >> (32 - MD5_S[i]));
            b   = b + tmp;
        end
        a = a + 32'h67452301; b = b + 32'hefcdab89; c = c + 32'h98badcfe; d = d + 32'h10325476;
        return {bswap(a), bswap(b), bswap(c), bswap(d)};
    endfunction

    // MD5 core stand-in: one outstanding request, a new md5_start replaces it.
    always @(negedge clk) begin
        md5_done = 1'b0;
        if (reset) begin
            pend_at = -1;
        end else begin
            if (md5_start) begin
                pend_at   = cyc + 64;
                pend_hash = md5_win(md5_msg);
            end
            if (pend_at == cyc) begin
                md5_done = 1'b1;
                md5_hash = pend_hash;
                pend_at  = -1;
            end
        end
    end

    always @(negedge clk) begin
        if (md5_start) start_cyc_q.push_back(cyc);
        if (proc_done) begin
            done_cyc_q.push_back(cyc);
            done_match_q.push_back(int'(proc_match));
            done_pos_q.push_back(int'(proc_byte_pos));
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic int count_after(input int q [$], input int c);
        int n = 0;
        foreach (q[i]) if (q[i] > c) n++;
        return n;
    endfunction

    task automatic start_job(input vec_t v, output int s_cyc, output int t_cyc);
        logic [31:0]      s;
        logic [WIN_W-1:0] w;
        s = 32'(v.seed);
        for (int i = 0; i < v.num_bytes; i++) begin
            if (v.kind == 0) begin
                data_mem[i] = 8'h61 + 8'(i % 26);
            end else begin
                s = s * 32'd1103515245 + 32'd12345;
                data_mem[i] = s[23:16];
            end
        end
        if (v.tgt_pos >= 0) begin
            for (int j = 0; j < STR_LEN; j++) w[WIN_W-1-8*j -: 8] = data_mem[v.tgt_pos + j];
            proc_target_hash = md5_win(w);
        end else begin
            proc_target_hash = UNRELATED;
        end
        @(negedge clk);
        proc_start     = 1'b1;
        proc_num_bytes = 16'(v.num_bytes);
        s_cyc          = cyc;
        @(negedge clk);
        proc_start = 1'b0;
        t_cyc      = s_cyc;
        for (int i = 0; i < v.num_bytes; i++) begin
            if (i > 0) @(negedge clk);
            proc_data_valid = 1'b1;
            proc_data       = data_mem[i];
            t_cyc           = cyc;
        end
        if (v.num_bytes > 0) begin
            @(negedge clk);
            proc_data_valid = 1'b0;
        end
    endtask

    task automatic finish_job(input vec_t v, input string tag, input int s_cyc, input int t_cyc);
        int k, n_starts, bad_gap, first_st, last_st, d_idx, d_cyc, d_match, d_pos, exp_done;
        k = 0;
        while (count_after(done_cyc_q, s_cyc) == 0 && k < 20000) begin
            @(negedge clk);
            k++;
        end
        @(negedge clk);
        n_starts = 0; bad_gap = 0; first_st = -1; last_st = -1;
        foreach (start_cyc_q[i]) begin
            if (start_cyc_q[i] > s_cyc) begin
                if (n_starts == 0) first_st = start_cyc_q[i];
                else if (start_cyc_q[i] - last_st != 67) bad_gap++;
                last_st = start_cyc_q[i];
                n_starts++;
            end
        end
        d_idx = -1;
        foreach (done_cyc_q[i]) if (done_cyc_q[i] > s_cyc && d_idx < 0) d_idx = i;
        d_cyc = -1; d_match = -1; d_pos = -1;
        if (d_idx >= 0) begin
            d_cyc = done_cyc_q[d_idx]; d_match = done_match_q[d_idx]; d_pos = done_pos_q[d_idx];
        end
        if (v.exp_starts > 0)      exp_done = last_st + 65;
        else if (v.num_bytes == 0) exp_done = s_cyc + 2;
        else                       exp_done = t_cyc + 1;
        check({tag, "_done_cnt"}, count_after(done_cyc_q, s_cyc), 1);
        check({tag, "_starts"}, n_starts, v.exp_starts);
        check({tag, "_match"}, d_match, int'(v.exp_match));
        check({tag, "_pos"}, d_pos, v.exp_pos);
        check({tag, "_done_cyc"}, d_cyc, exp_done);
        if (v.exp_starts > 0) check({tag, "_first_start"}, first_st, t_cyc + 21);
        if (v.exp_starts > 1) check({tag, "_start_gaps"}, bad_gap, 0);
        repeat (3) @(negedge clk);
        check({tag, "_hold_match"}, proc_match, v.exp_match);
        check({tag, "_hold_pos"}, proc_byte_pos, v.exp_pos);
    endtask

    task automatic readback(input string tag, input int base);
        for (int i = 0; i <= STR_LEN; i++) begin
            check($sformatf("%s_char%0d", tag, i), proc_match_char, data_mem[base + (i % STR_LEN)]);
            proc_match_char_next = 1'b1;
            @(negedge clk);
            proc_match_char_next = 1'b0;
        end
    endtask

    initial begin
        #800us;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s_cyc, t_cyc, sa, ta, k, snap;

        //          bytes kind seed tgt  starts match pos
        vecs[0] = '{19,   0,   0,   0,   1,     1,    0 };  // single window
        vecs[1] = '{100,  1,   7,   37,  38,    1,    37};  // sliding match
        vecs[2] = '{40,   1,   11,  -1,  22,    0,    0 };  // no match
        vecs[3] = '{5,    0,   0,   -1,  0,     0,    0 };  // shorter than a window
        vecs[4] = '{0,    0,   0,   -1,  0,     0,    0 };  // empty job
        vecs[5] = '{50,   1,   23,  31,  32,    1,    31};  // match in last window
        vecs[6] = '{19,   1,   5,   -1,  1,     0,    0 };  // exactly one window, no match
        vecs[7] = '{18,   0,   0,   -1,  0,     0,    0 };  // one byte short

        reset = 1'b1; proc_start = 1'b0; proc_num_bytes = '0; proc_data = '0;
        proc_data_valid = 1'b0; proc_target_hash = '0; proc_match_char_next = 1'b0;
        md5_hash = '0;
        repeat (3) @(negedge clk);
        check("rst_done", proc_done, 0);
        check("rst_match", proc_match, 0);
        check("rst_pos", proc_byte_pos, 0);
        check("rst_char", proc_match_char, 0);
        check("rst_md5_start", md5_start, 0);
        check("rst_msg_zero", md5_msg == '0, 1);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        for (int v = 0; v < NVEC; v++) begin
            start_job(vecs[v], s_cyc, t_cyc);
            finish_job(vecs[v], $sformatf("v%0d", v), s_cyc, t_cyc);
            if (vecs[v].exp_match) readback($sformatf("v%0d_rb", v), vecs[v].exp_pos);
        end

        // Abort a no-match job while it waits for its first digest.
        start_job(vecs[2], sa, ta);
        k = 0;
        while (count_after(start_cyc_q, sa) == 0 && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("abort_a_started", count_after(start_cyc_q, sa) != 0, 1);
        repeat (30) @(negedge clk);
        start_job(vecs[0], s_cyc, t_cyc);
        finish_job(vecs[0], "abort_b", s_cyc, t_cyc);
        check("abort_done_total", count_after(done_cyc_q, sa), 1);

        // Data strobes while idle must not disturb the held result.
        snap = cyc;
        for (int i = 0; i < 5; i++) begin
            proc_data_valid = 1'b1;
            proc_data       = 8'h5a;
            @(negedge clk);
        end
        proc_data_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("idle_match", proc_match, 1);
        check("idle_pos", proc_byte_pos, 0);
        check("idle_char", proc_match_char, 8'h61);
        check("idle_starts", count_after(start_cyc_q, snap), 0);
        check("idle_dones", count_after(done_cyc_q, snap), 0);
        readback("idle_rb", 0);

        // Asynchronous reset in the middle of FILL.
        start_job(vecs[1], s_cyc, t_cyc);
        repeat (5) @(negedge clk);
        check("rstf_pre_msg_nonzero", md5_msg != '0, 1);
        #2 reset = 1'b1;
        #1;
        check("rstf_done", proc_done, 0);
        check("rstf_match", proc_match, 0);
        check("rstf_pos", proc_byte_pos, 0);
        check("rstf_char", proc_match_char, 0);
        check("rstf_md5_start", md5_start, 0);
        check("rstf_msg_zero", md5_msg == '0, 1);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        snap = cyc;
        repeat (100) @(negedge clk);
        check("rstf_no_start_after", count_after(start_cyc_q, snap), 0);
        start_job(vecs[0], s_cyc, t_cyc);
        finish_job(vecs[0], "recover", s_cyc, t_cyc);
        readback("recover_rb", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
